// File: rtl/axi_lite_pkg.sv
// AXI4-Lite shared definitions, common to the read and write responders.
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

endpackage : axi_lite_pkg

// File: rtl/axi_write_logic_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between interconnect and responder.
//
// Handshake rule for every channel: a transfer happens at a rising ACLK edge
// where both VALID and READY are 1. The source holds VALID and its payload
// steady until that edge; the sink may raise or drop READY at any time.
interface axi_write_logic_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );

endinterface : axi_write_logic_if

// File: rtl/axi_write_regbank.sv
// Local register bank for the AXI4-Lite write responder: storage, byte merge,
// synchronous clear and an asynchronous read port.
// Optional feature macro: AXI_WSTRB_EN (byte-strobe merge; otherwise full-word writes).
module axi_write_regbank #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic [DATA_W-1:0]   merged,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] bank [DEPTH];

`ifdef AXI_WSTRB_EN
    // Strobed bytes come from the new data, the rest keep the stored word.
    always_comb begin
        merged = bank[wr_addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_strb[i]) begin
                merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end
`else
    // Without strobes every write replaces the whole word.
    always_comb begin
        merged = wr_data;
    end

    logic unused_strb;
    assign unused_strb = ^wr_strb;
`endif

    // Bank storage: cleared on reset, written with the merged word on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_addr] <= merged;
        end
    end

    assign rd_data = bank[rd_addr];

endmodule : axi_write_regbank

// File: rtl/axi_write_logic.sv
// AXI4-Lite write responder: takes AW and W independently and in any order,
// commits the merged word into the local bank, then answers on B.
// Only one transaction is in flight; new handshakes wait until B completes.
// Optional feature macro: AXI_WSTRB_EN (honour WSTRB byte strobes).
module axi_write_logic
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi_write_logic_if.slave  axi,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    logic                awready_q;
    logic                wready_q;
    logic                bvalid_q;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic [DATA_W-1:0]   merged;
    logic                commit;

    // Both halves captured and no response outstanding.
    assign commit = aw_done & w_done & ~bvalid_q;

    // AW channel: one-cycle ready pulse per transaction, address capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            aw_done   <= 1'b0;
            aw_addr_q <= '0;
        end else begin
            awready_q <= axi.AWVALID & ~awready_q & ~aw_done & ~bvalid_q;
            if (commit) begin
                aw_done <= 1'b0;
            end else if (axi.AWVALID & awready_q) begin
                aw_done   <= 1'b1;
                aw_addr_q <= axi.AWADDR;
            end
        end
    end

    // W channel: one-cycle ready pulse per transaction, data/strobe capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wready_q <= 1'b0;
            w_done   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            wready_q <= axi.WVALID & ~wready_q & ~w_done & ~bvalid_q;
            if (commit) begin
                w_done <= 1'b0;
            end else if (axi.WVALID & wready_q) begin
                w_done   <= 1'b1;
                w_data_q <= axi.WDATA;
                w_strb_q <= axi.WSTRB;
            end
        end
    end

    // Commit: publish address/merged word with a one-cycle strobe and raise B.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bvalid_q   <= 1'b0;
            data_valid <= 1'b0;
            addr_out   <= '0;
            data_out   <= '0;
        end else begin
            data_valid <= commit;
            if (commit) begin
                bvalid_q <= 1'b1;
                addr_out <= aw_addr_q;
                data_out <= merged;
            end else if (bvalid_q & axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    axi_write_regbank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regbank (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .wr_en   (commit),
        .wr_addr (aw_addr_q),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q),
        .merged  (merged),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BRESP   = RESP_OKAY;

endmodule : axi_write_logic

// File: tb/tb_axi_write_logic.sv
// Directed and randomized bench for axi_write_logic, with a word-array model
// of the register bank and an expected queue of committed address/data pairs.
module tb_axi_write_logic;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int NB     = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0]        model_bank [DEPTH];
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    axi_write_logic_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_write_logic #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .axi        (axi),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    // Clock and reset
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference merge: byte mask from strobes, or the whole word without strobes.
    function automatic logic [DATA_W-1:0] model_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] d,
                                                      input logic [NB-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{s[i]}};
`ifndef AXI_WSTRB_EN
        m = '1;
`endif
        return (d & m) | (old & ~m);
    endfunction

    task automatic do_reset(input int cycles);
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;
        ARESET = 1'b1;
        repeat (cycles) tick();
        ARESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_bank[i] = '0;
        exp_q.delete();
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            chk(tag, rd_data, model_bank[i]);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_awready"}, axi.AWREADY, 0);
        chk({tag, "_wready"}, axi.WREADY, 0);
        chk({tag, "_bvalid"}, axi.BVALID, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_addr_out"}, addr_out, 0);
        chk({tag, "_data_out"}, data_out, 0);
        check_bank({tag, "_bank"});
    endtask

    // Driver: AW and W each start after their own delay; checks the commit cycle.
    task automatic write_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [NB-1:0] s, input int aw_dly, input int w_dly);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        bit aw_hs, w_hs;
        int cyc = 0;
        logic [DATA_W-1:0]        exp_word;
        logic [ADDR_W+DATA_W-1:0] e;
        while ((aw_pend || w_pend) && cyc < 60) begin
            if (aw_pend && cyc >= aw_dly) begin axi.AWVALID = 1'b1; axi.AWADDR = a; end
            if (w_pend && cyc >= w_dly) begin axi.WVALID = 1'b1; axi.WDATA = d; axi.WSTRB = s; end
            aw_hs = axi.AWVALID && axi.AWREADY;
            w_hs  = axi.WVALID && axi.WREADY;
            tick();
            if (aw_hs) begin aw_pend = 1'b0; axi.AWVALID = 1'b0; end
            if (w_hs) begin w_pend = 1'b0; axi.WVALID = 1'b0; end
            if (aw_pend || w_pend) chk("no_early_bvalid", axi.BVALID, 0);
            cyc++;
        end
        if (aw_pend || w_pend) begin
            chk("handshake_timeout", 1, 0);
            axi.AWVALID = 1'b0;
            axi.WVALID  = 1'b0;
            return;
        end
        chk("bvalid_before_commit", axi.BVALID, 0);
        exp_word = model_merge(model_bank[a], d, s);
        exp_q.push_back({a, exp_word});
        tick();
        chk("commit_bvalid", axi.BVALID, 1);
        chk("commit_strobe", data_valid, 1);
        chk("bresp_okay", axi.BRESP, 2'b00);
        e = exp_q.pop_front();
        chk("addr_out", addr_out, e[DATA_W +: ADDR_W]);
        chk("data_out", data_out, e[DATA_W-1:0]);
        model_bank[a] = exp_word;
        rd_addr = a;
        #1;
        chk("rd_after_commit", rd_data, exp_word);
    endtask

    // Driver: hold BREADY low for bdly cycles, then complete B.
    task automatic b_resp(input int bdly);
        for (int i = 0; i < bdly; i++) begin
            tick();
            chk("bvalid_hold", axi.BVALID, 1);
            chk("strobe_one_cycle", data_valid, 0);
            chk("awready_blocked", axi.AWREADY, 0);
            chk("wready_blocked", axi.WREADY, 0);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
        chk("bvalid_cleared", axi.BVALID, 0);
        chk("strobe_low", data_valid, 0);
        chk("awready_after_b", axi.AWREADY, 0);
    endtask

    logic [DATA_W-1:0] strb_exp;
    bit                hs;

    initial begin
        axi.AWADDR = '0; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0;
        axi.BREADY = 1'b0;
        rd_addr = '0;
        ARESET = 1'b1;

        // Reset state
        do_reset(2);
        check_idle("reset");
        chk("reset_bresp", axi.BRESP, 2'b00);

        // Simultaneous AW/W, immediate BREADY
        write_req(2'd1, 32'hDEADBEEF, 4'hF, 0, 0);
        b_resp(0);
        rd_addr = 2'd1;
        #1;
        chk("t1_rd_data", rd_data, 32'hDEADBEEF);

        // W three cycles ahead of AW: one commit, one B
        write_req(2'd2, 32'h12345678, 4'hF, 3, 0);
        b_resp(1);
        repeat (3) begin
            tick();
            chk("t2_single_b", axi.BVALID, 0);
            chk("t2_single_strobe", data_valid, 0);
        end

        // BREADY held low while the next request is already waiting
        write_req(2'd0, 32'hCAFEF00D, 4'hF, 0, 0);
        axi.AWVALID = 1'b1; axi.AWADDR = 2'd3;
        axi.WVALID = 1'b1; axi.WDATA = 32'h0BADC0DE; axi.WSTRB = 4'hF;
        b_resp(5);
        chk("t3_wready_after_b", axi.WREADY, 0);
        write_req(2'd3, 32'h0BADC0DE, 4'hF, 0, 0);
        b_resp(0);

        // Partial-strobe write over a known word
        write_req(2'd0, 32'hAABBCCDD, 4'hF, 0, 0);
        b_resp(0);
        write_req(2'd0, 32'h11223344, 4'b0101, 1, 0);
        b_resp(2);
`ifdef AXI_WSTRB_EN
        strb_exp = 32'hAA22CC44;
`else
        strb_exp = 32'h11223344;
`endif
        rd_addr = 2'd0;
        #1;
        chk("strobe_merge", rd_data, strb_exp);

        // Reset after AW handshake, before any W
        axi.AWVALID = 1'b1; axi.AWADDR = 2'd2;
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) begin
            hs = axi.AWREADY;
            tick();
        end
        axi.AWVALID = 1'b0;
        chk("t6_aw_handshake", hs, 1);
        tick();
        chk("t6_no_b_without_w", axi.BVALID, 0);
        do_reset(1);
        check_idle("t6_after_reset");
        write_req(2'd2, 32'h55AA55AA, 4'hF, 4, 0);
        b_resp(0);
        check_bank("t6_bank");

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            write_req(ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom),
                      NB'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 4));
            b_resp($urandom_range(0, 3));
        end
        check_bank("random_bank");
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axi_write_logic
